// File: rtl/hba_speed_meter.sv
// -----------------------------------------------------------------------------
// hba_speed_meter
//
// Purpose:
//   Measures wheel speed from a single-channel encoder tick. Rising edges of
//   the (synchronised) encoder input are counted over a fixed window of
//   WINDOW_CYCLES clocks. At the end of each window the saturated count is
//   published on speed together with a one-cycle speed_valid strobe. The
//   outputs feed the speed-control comparator: speed -> in1, speed_valid -> en.
//
// Parameters:
//   WINDOW_CYCLES  clocks per sample window (4 .. 2^24-1)
//   SYNC_STAGES    flops in the enc_in synchroniser (2 .. 3)
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-low reset
//   en           in   measurement enable, synchronous to clk
//   enc_in       in   raw encoder tick, asynchronous to clk
//   speed        out  [7:0] edge count of last completed window, saturated at 255
//   speed_valid  out  one-cycle strobe, speed/overflow updated this cycle
//   overflow     out  last completed window saturated (true count > 255)
// -----------------------------------------------------------------------------
module hba_speed_meter #(
  parameter int WINDOW_CYCLES = 500000,
  parameter int SYNC_STAGES   = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       enc_in,
  output logic [7:0] speed,
  output logic       speed_valid,
  output logic       overflow
);

  localparam int CW = $clog2(WINDOW_CYCLES);
  localparam logic [CW-1:0] WIN_LAST = CW'(WINDOW_CYCLES - 1);

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_MEASURE = 1'b1
  } state_t;

  state_t                 r_state;
  state_t                 w_next_state;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_prev;
  logic [CW-1:0]          r_win;
  logic [7:0]             r_ticks;
  logic                   r_sat;
  logic [7:0]             r_speed;
  logic                   r_speed_valid;
  logic                   r_overflow;

  logic                   w_edge;
  logic                   w_close;
  logic                   w_tick_full;
  logic [7:0]             w_ticks_upd;
  logic                   w_sat_upd;

  // ---------------------------------------------------------------------------
  // Synchroniser and rising-edge detector. These run every cycle regardless of
  // en or state, so a level already present at reset release still produces
  // exactly one edge SYNC_STAGES cycles later.
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is always assigned with <= so every flop samples
  // the pre-edge value of its sources; a blocking = here would collapse the
  // synchroniser chain into a single stage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync <= '0;
      r_prev <= 1'b0;
    end else begin
      if (SYNC_STAGES > 1) begin
        r_sync <= {r_sync[SYNC_STAGES-2:0], enc_in};
      end else begin
        r_sync <= enc_in;
      end
      r_prev <= r_sync[SYNC_STAGES-1];
    end
  end

  assign w_edge = r_sync[SYNC_STAGES-1] & ~r_prev;

  // ---------------------------------------------------------------------------
  // Tick count including this cycle's edge, saturated at 255. The sat flag
  // remembers that a further edge arrived while the count was already full.
  // ---------------------------------------------------------------------------
  assign w_tick_full = (r_ticks == 8'hFF);
  assign w_ticks_upd = (w_edge && !w_tick_full) ? (r_ticks + 8'd1) : r_ticks;
  assign w_sat_upd   = r_sat | (w_edge & w_tick_full);
  assign w_close     = (r_state == ST_MEASURE) && (r_win == WIN_LAST);

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic. A window close with en low still completes (handled in
  // the datapath); the FSM simply lands in IDLE afterwards either way.
  // ---------------------------------------------------------------------------
  // NOTE: the default assignment at the top guarantees w_next_state is written
  // on every path, so no latch is inferred.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_IDLE:    if (en)  w_next_state = ST_MEASURE;
      ST_MEASURE: if (!en) w_next_state = ST_IDLE;
      default:    w_next_state = ST_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Window / tick counters and registered outputs.
  //   close        : publish count (including this cycle's edge), restart.
  //   measure & en : advance window, accumulate ticks.
  //   otherwise    : IDLE or aborted window -> counters cleared, outputs kept.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_win         <= '0;
      r_ticks       <= 8'd0;
      r_sat         <= 1'b0;
      r_speed       <= 8'd0;
      r_speed_valid <= 1'b0;
      r_overflow    <= 1'b0;
    end else begin
      r_speed_valid <= 1'b0;
      if (w_close) begin
        r_speed       <= w_ticks_upd;
        r_overflow    <= w_sat_upd;
        r_speed_valid <= 1'b1;
        r_win         <= '0;
        r_ticks       <= 8'd0;
        r_sat         <= 1'b0;
      end else if (r_state == ST_MEASURE && en) begin
        r_win   <= r_win + CW'(1);
        r_ticks <= w_ticks_upd;
        r_sat   <= w_sat_upd;
      end else begin
        r_win   <= '0;
        r_ticks <= 8'd0;
        r_sat   <= 1'b0;
      end
    end
  end

  assign speed       = r_speed;
  assign speed_valid = r_speed_valid;
  assign overflow    = r_overflow;

endmodule

// File: tb/tb_hba_speed_meter.sv
// -----------------------------------------------------------------------------
// tb_hba_speed_meter
//
// Two instances: inst 0 uses a 100-cycle window, inst 1 a 600-cycle window
// (needed to push more than 255 edges into one window). A reference model
// counts true encoder edges per window from the raw stimulus history and
// pushes the expected report into a per-instance queue; a monitor pops and
// compares whenever speed_valid is seen, and also checks that speed/overflow
// hold their last reported values between strobes.
// -----------------------------------------------------------------------------
module tb_hba_speed_meter;

  localparam int SYNC = 2;

  typedef struct {
    int cyc;
    int speed;
    bit ovf;
  } exp_t;

  logic       clk = 1'b0;
  logic       rst_v [2];
  logic       en_v  [2];
  logic       enc_v [2];
  logic [7:0] spd   [2];
  logic       vld   [2];
  logic       ovf   [2];

  exp_t q0[$];
  exp_t q1[$];

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // Reference model state (per instance)
  bit          m_meas [2];
  int          m_win  [2];
  int          m_cnt  [2];
  logic [31:0] m_hist [2];
  int          m_spd  [2];
  bit          m_ovf  [2];

  always #5 clk = ~clk;

  hba_speed_meter #(.WINDOW_CYCLES(100), .SYNC_STAGES(SYNC)) dut (
    .clk(clk), .reset(rst_v[0]), .en(en_v[0]), .enc_in(enc_v[0]),
    .speed(spd[0]), .speed_valid(vld[0]), .overflow(ovf[0])
  );

  hba_speed_meter #(.WINDOW_CYCLES(600), .SYNC_STAGES(SYNC)) dut_big (
    .clk(clk), .reset(rst_v[1]), .en(en_v[1]), .enc_in(enc_v[1]),
    .speed(spd[1]), .speed_valid(vld[1]), .overflow(ovf[1])
  );

  function automatic int wc(input int i);
    return (i == 0) ? 100 : 600;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, act, req);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: evaluated at every rising clock with the inputs the
  // driver set on the preceding falling edge. An encoder rise sampled at
  // clock k is seen by the counter at clock k+SYNC.
  // ---------------------------------------------------------------------------
  initial begin : model_p
    bit   e;
    exp_t it;
    forever begin
      @(posedge clk);
      cyc++;
      for (int i = 0; i < 2; i++) begin
        if (rst_v[i] !== 1'b1) begin
          m_meas[i] = 1'b0; m_win[i] = 0; m_cnt[i] = 0;
          m_hist[i] = '0;   m_spd[i] = 0; m_ovf[i] = 1'b0;
        end else begin
          m_hist[i] = (m_hist[i] << 1) | 32'(enc_v[i]);
          e = m_hist[i][SYNC] & ~m_hist[i][SYNC+1];
          if (!m_meas[i]) begin
            if (en_v[i]) begin
              m_meas[i] = 1'b1; m_win[i] = 0; m_cnt[i] = 0;
            end
          end else begin
            if (e) m_cnt[i]++;
            if (m_win[i] == wc(i) - 1) begin
              it.cyc   = cyc;
              it.speed = (m_cnt[i] > 255) ? 255 : m_cnt[i];
              it.ovf   = (m_cnt[i] > 255);
              if (i == 0) q0.push_back(it); else q1.push_back(it);
              m_spd[i]  = it.speed;
              m_ovf[i]  = it.ovf;
              m_cnt[i]  = 0;
              m_win[i]  = 0;
              m_meas[i] = en_v[i];
            end else if (!en_v[i]) begin
              m_meas[i] = 1'b0; m_win[i] = 0; m_cnt[i] = 0;
            end else begin
              m_win[i]++;
            end
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Monitor: samples 1 time unit after each rising edge.
  // ---------------------------------------------------------------------------
  initial begin : monitor_p
    bit   have;
    bit   due;
    exp_t f;
    forever begin
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        have = (i == 0) ? (q0.size() > 0) : (q1.size() > 0);
        if (have) f = (i == 0) ? q0[0] : q1[0];
        due = have && (f.cyc == cyc);
        check($sformatf("speed_valid[%0d]", i), 32'(vld[i]), 32'(due));
        if (due) begin
          if (i == 0) q0.delete(0); else q1.delete(0);
          check($sformatf("strobe_speed[%0d]", i), 32'(spd[i]), 32'(f.speed));
          check($sformatf("strobe_overflow[%0d]", i), 32'(ovf[i]), 32'(f.ovf));
        end
        check($sformatf("speed_hold[%0d]", i), 32'(spd[i]), 32'(m_spd[i]));
        check($sformatf("overflow_hold[%0d]", i), 32'(ovf[i]), 32'(m_ovf[i]));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers (all changes on the falling edge)
  // ---------------------------------------------------------------------------
  task automatic drive(input int i, input bit e, input bit x);
    @(negedge clk);
    en_v[i]  = e;
    enc_v[i] = x;
  endtask

  task automatic pulses(input int i, input int n, input int hi, input int lo);
    repeat (n) begin
      repeat (hi) drive(i, 1'b1, 1'b1);
      repeat (lo) drive(i, 1'b1, 1'b0);
    end
  endtask

  task automatic toggle(input int i, input int n);
    for (int k = 0; k < n; k++) drive(i, 1'b1, k[0]);
  endtask

  task automatic quiet(input int i, input int n, input bit e);
    repeat (n) drive(i, e, 1'b0);
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin
    for (int i = 0; i < 2; i++) begin
      rst_v[i] = 1'b0; en_v[i] = 1'b0; enc_v[i] = 1'b0;
    end

    // 1. Reset held with encoder toggling, then idle with en low.
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      enc_v[0] = k[0];
      enc_v[1] = ~k[0];
      en_v[0]  = k[1];
    end
    check("reset_speed", 32'(spd[0]), 32'd0);
    check("reset_valid", 32'(vld[0]), 32'd0);
    check("reset_overflow", 32'(ovf[0]), 32'd0);
    @(negedge clk);
    rst_v[0] = 1'b1; rst_v[1] = 1'b1;
    en_v[0]  = 1'b0; en_v[1]  = 1'b0;
    enc_v[1] = 1'b0;
    for (int k = 0; k < 300; k++) drive(0, 1'b0, 1'($urandom_range(0, 1)));

    // 2. Ten clean pulses in the first window, then an empty window.
    drive(0, 1'b1, 1'b0);
    pulses(0, 10, 4, 4);
    quiet(0, 125, 1'b1);

    // 3a. Toggle every cycle for a window, then 5 clean pulses.
    quiet(0, 3, 1'b0);
    drive(0, 1'b1, 1'b0);
    toggle(0, 100);
    pulses(0, 5, 4, 4);
    quiet(0, 70, 1'b1);

    // 3b. Large window: 300 edges saturate, next window of 5 is clean.
    quiet(0, 3, 1'b0);
    drive(1, 1'b1, 1'b0);
    toggle(1, 600);
    pulses(1, 5, 4, 4);
    quiet(1, 570, 1'b1);
    quiet(1, 3, 1'b0);

    // 4. Edge detected exactly in the close cycle of the window.
    drive(0, 1'b1, 1'b0);
    for (int k = 1; k <= 220; k++) begin
      if (k <= 96)       drive(0, 1'b1, 1'((k / 4) % 2));
      else if (k == 97)  drive(0, 1'b1, 1'b0);
      else if (k <= 110) drive(0, 1'b1, 1'b1);
      else               drive(0, 1'b1, 1'b0);
    end

    // Randomised operation: random encoder levels, rare enable drops.
    for (int k = 0; k < 600; k++) begin
      drive(0, ($urandom_range(0, 59) != 0), 1'($urandom_range(0, 1)));
    end
    quiet(0, 3, 1'b0);

    // 5. Abort a window at cycle 60 after 7 edges, then a fresh window.
    drive(0, 1'b1, 1'b0);
    pulses(0, 7, 4, 4);
    quiet(0, 4, 1'b1);
    quiet(0, 10, 1'b0);
    drive(0, 1'b1, 1'b0);
    pulses(0, 3, 4, 4);
    quiet(0, 90, 1'b1);

    // 6. Reset asserted mid-window, then re-release with en high.
    quiet(0, 3, 1'b0);
    drive(0, 1'b1, 1'b0);
    pulses(0, 6, 4, 4);
    quiet(0, 2, 1'b1);
    @(negedge clk);
    rst_v[0] = 1'b0;
    #1;
    check("async_reset_speed", 32'(spd[0]), 32'd0);
    check("async_reset_valid", 32'(vld[0]), 32'd0);
    check("async_reset_overflow", 32'(ovf[0]), 32'd0);
    quiet(0, 3, 1'b1);
    @(negedge clk);
    rst_v[0] = 1'b1;
    en_v[0]  = 1'b1;
    pulses(0, 2, 4, 4);
    quiet(0, 110, 1'b1);

    // Drain and summarise.
    quiet(0, 5, 1'b0);
    quiet(1, 5, 1'b0);
    check("outstanding_strobes", 32'(q0.size() + q1.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hba_speed_meter.md
Name: hba_speed_meter

Overview:
- Measures wheel speed from a single-channel encoder tick input by counting rising edges over a fixed sample window.
- Once per window it emits an 8-bit speed value and a one-cycle strobe.
- Sits directly upstream of the speed-control comparator: speed drives in1, speed_valid drives en.

Parameters:
- WINDOW_CYCLES, 500000, clock cycles per sample window (10 ms at 50 MHz). Legal range 4..2^24-1. Window counter width is clog2(WINDOW_CYCLES).
- SYNC_STAGES, 2, flip-flop stages in the enc_in synchronizer. Legal range 2..3.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  measurement enable, synchronous to clk.
- enc_in  input  1  raw encoder tick, asynchronous to clk.
- speed  output  8  edge count of the last completed window, saturated at 255.
- speed_valid  output  1  one-cycle strobe; speed updated this cycle.
- overflow  output  1  last completed window saturated (true count exceeded 255).

Behaviour:
- Reset (reset=0, asynchronous assert, synchronous deassert handled upstream):
  - speed=0, speed_valid=0, overflow=0.
  - Synchronizer flops, edge-detect prev flop, tick counter and window counter all 0.
  - State = IDLE.
- Synchronizer and edge detect:
  - enc_in passes through SYNC_STAGES flops. These flops and the prev flop run every cycle regardless of en or state.
  - edge = sync_out & ~prev.
  - Latency: an enc_in rise at the edge of cycle N is detected as edge in cycle N+SYNC_STAGES.
  - If enc_in is already high at reset release, it produces one edge SYNC_STAGES cycles later. That edge is counted only if in MEASURE.
- State machine:
  - IDLE: counters held at 0, no strobes. If en=1, go to MEASURE; the window counter starts at 0 on the next cycle.
  - MEASURE:
    - Window counter increments each cycle.
    - Tick counter increments on edge, saturating at 255. A sat flag is set if an edge arrives while the count is 255.
    - If en=0: go to IDLE. Clear both counters and sat. The partial window is discarded: no strobe, and speed/overflow retain their values.
- Window close, in MEASURE with window counter = WINDOW_CYCLES-1:
  - speed <= tick count including any edge in this same cycle, saturated.
  - overflow <= sat, or saturation caused by this cycle's edge.
  - speed_valid = 1 for exactly this one cycle.
  - Window counter, tick counter and sat clear to 0. An edge in this cycle belongs to the closing window, never the new one.
  - Windows are back-to-back: exactly WINDOW_CYCLES cycles between successive strobes while en stays 1.
- Simultaneous events:
  - en falling in the close cycle: the close completes (strobe and update happen), then the block goes to IDLE.
  - en does not gate the synchronizer.
- Outputs are registered. speed and overflow are stable between strobes.
- Async reset mid-window: outputs return to reset values immediately; the partial count is lost.

Test Plan (WINDOW_CYCLES=100, SYNC_STAGES=2):
1. Reset held, enc_in toggling -> speed=0, speed_valid=0, overflow=0. After release with en=0 for 300 cycles -> no strobe.
2. en=1, 10 clean pulses (4 cycles high, 4 low) within the first window -> speed_valid pulses once, exactly 100 cycles after MEASURE entry, with speed=10, overflow=0. The next window with no pulses -> speed=0.
3. enc_in toggling every cycle (50 edges), and separately WINDOW_CYCLES=600 with 300 edges -> first case speed=50, overflow=0; second case speed=255, overflow=1. The following clean window of 5 edges -> speed=5, overflow=0.
4. Edge detected exactly on the close cycle -> counted in the closing window (speed=N+1); the new window starts at 0.
5. en dropped at cycle 60 with 7 edges counted -> no strobe; speed keeps its prior value. Re-raise en -> a fresh full 100-cycle window reports only new edges.
6. Reset asserted at cycle 50 of a window -> outputs clear immediately. After release with en=1 -> first strobe arrives a full 100 cycles after MEASURE entry.
